// File: rtl/result_stream_reader.sv
// Result matrix read-back: waits for the cores to finish, then streams
// NUM_ELEM DRAM bytes on valid/ready through a 2-entry latency FIFO.
module result_stream_reader #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter int                NUM_CORES = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0024,
  parameter int                NUM_ELEM  = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NUM_CORES-1:0] i_busy,
  output logic                 o_dram_read,
  output logic [ADDR_W-1:0]    o_dram_addr,
  input  logic [DATA_W-1:0]    i_dram_data,
  output logic [DATA_W-1:0]    o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [7:0]           o_count
);

  localparam int CNT_W = $clog2(NUM_ELEM + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEM - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_CORES,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  issued;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic [7:0]        count;

  logic       idle_like;
  logic       start_acc;
  logic       pop;
  logic       push;
  logic [1:0] pending;
  logic       credit;
  logic       issue;

  assign idle_like = (state == IDLE) || (state == DONE);
  assign start_acc = idle_like && i_start;
  assign o_valid   = (occ != 2'd0);
  assign pop       = o_valid && i_ready;
  assign push      = inflight;

  // FIFO slots plus the read still in flight must never exceed two
  assign pending = occ + {1'b0, inflight};
  assign credit  = (pending < 2'd2) || pop;
  assign issue   = (state == READ) && credit;

  assign o_dram_read = issue;
  assign o_dram_addr = addr;
  assign o_data      = fifo_mem[rd_ptr];
  assign o_busy      = !idle_like;
  assign o_done      = (state == DONE);
  assign o_count     = count;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (i_start) state_nxt = ARM;
      ARM:        if (|i_busy) state_nxt = WAIT_CORES;
      WAIT_CORES: if (i_busy == '0) state_nxt = READ;
      READ:       if (issue && (issued == LAST)) state_nxt = DRAIN;
      DRAIN:      if (!inflight && (occ == 2'd0)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr        <= '0;
      issued      <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      count       <= 8'd0;
    end else if (start_acc) begin
      addr     <= BASE_ADDR;
      issued   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
      count    <= 8'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        addr   <= addr + ADDR_W'(1);
        issued <= issued + CNT_W'(1);
      end
      if (push) begin
        fifo_mem[wr_ptr] <= i_dram_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (count != 8'hFF) count <= count + 8'd1;
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: DRAM model, stream monitor,
// one task per scenario.
module tb_result_stream_reader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [3:0]  i_busy;
  logic        o_dram_read;
  logic [15:0] o_dram_addr;
  logic [7:0]  i_dram_data;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_count;

  int vec = 0;
  int err = 0;

  logic [7:0] exp_data [18] = '{
    8'h7C, 8'h2D, 8'hC2, 8'h49, 8'hC4, 8'h31, 8'h44, 8'h43, 8'hCB,
    8'h58, 8'h69, 8'h5F, 8'hDC, 8'h7D, 8'h1F, 8'hB1, 8'hBF, 8'hC7};

  result_stream_reader dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_busy      (i_busy),
    .o_dram_read (o_dram_read),
    .o_dram_addr (o_dram_addr),
    .i_dram_data (i_dram_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_count     (o_count)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] dram_val(input logic [15:0] a);
    if (a >= 16'h0024 && a <= 16'h0035) return exp_data[a - 16'h0024];
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge i_clk)
    if (o_dram_read) i_dram_data <= dram_val(o_dram_addr);

  logic [15:0] rd_addr [$];
  int          rd_cyc [$];
  logic [7:0]  data_q [$];
  int          data_cyc [$];
  int          cyc = 0;
  int          stall_viol = 0;
  int          stab_viol = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(negedge i_clk) begin
    int outst;
    cyc++;
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      outst = rd_addr.size() - data_q.size();
      if (prev_stall && (!o_valid || o_data !== prev_data)) stab_viol++;
      if (o_dram_read) begin
        if (outst >= 2 && !(o_valid && i_ready)) stall_viol++;
        rd_addr.push_back(o_dram_addr);
        rd_cyc.push_back(cyc);
      end
      if (o_valid && i_ready) begin
        data_q.push_back(o_data);
        data_cyc.push_back(cyc);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr.delete();
    rd_cyc.delete();
    data_q.delete();
    data_cyc.delete();
    stall_viol = 0;
    stab_viol  = 0;
  endtask

  task automatic start_pass();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_busy  = 4'b0011;
    repeat (10) tick();
    i_busy  = 4'b0000;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 0; i_busy = 0; i_ready = 0;
    tick(); tick();
    vec++;
    if ({o_valid, o_dram_read, o_busy, o_done} !== 4'b0000) begin
      err++;
      $display("FAIL por_flags got %b want 0000",
               {o_valid, o_dram_read, o_busy, o_done});
    end
    vec++;
    if (o_count !== 8'd0 || o_dram_addr !== 16'd0) begin
      err++;
      $display("FAIL por_regs count %0d addr %h want 0/0", o_count, o_dram_addr);
    end
    i_rst = 1'b0;
    tick();
    clear_log();
    i_ready = 1'b1;
    start_pass();
    repeat (6) tick();
    vec++;
    if (o_dram_read !== 1'b1 || o_count == 8'd0) begin
      err++;
      $display("FAIL mid_read read %b count %0d want 1/>0", o_dram_read, o_count);
    end
    i_rst = 1'b1;
    #1;
    vec++;
    if ({o_valid, o_dram_read, o_busy} !== 3'b000 || o_count !== 8'd0) begin
      err++;
      $display("FAIL async_rst v/r/b %b count %0d want 000/0",
               {o_valid, o_dram_read, o_busy}, o_count);
    end
    tick();
    i_rst = 1'b0;
    tick();
    vec++;
    if ({o_busy, o_done, o_valid, o_dram_read} !== 4'b0000 ||
        o_dram_addr !== 16'd0) begin
      err++;
      $display("FAIL post_rst_idle flags %b addr %h want 0000/0000",
               {o_busy, o_done, o_valid, o_dram_read}, o_dram_addr);
    end
  endtask

  task automatic test_happy();
    bit ok;
    clear_log();
    i_ready = 1'b1;
    start_pass();
    wait_done(200, ok);
    vec++;
    if (!ok) begin
      err++;
      $display("FAIL happy_done timeout got 0 want 1");
    end
    vec++;
    if (rd_addr.size() != 18 || data_q.size() != 18) begin
      err++;
      $display("FAIL happy_len reads %0d xfers %0d want 18/18",
               rd_addr.size(), data_q.size());
    end
    for (int i = 0; i < 18 && i < rd_addr.size() && i < data_q.size(); i++) begin
      vec++;
      if (rd_addr[i] !== 16'h0024 + 16'(i) || rd_cyc[i] != rd_cyc[0] + i) begin
        err++;
        $display("FAIL happy_rd[%0d] addr %h cyc %0d want %h/%0d", i,
                 rd_addr[i], rd_cyc[i], 16'h0024 + 16'(i), rd_cyc[0] + i);
      end
      vec++;
      if (data_q[i] !== exp_data[i] || data_cyc[i] != data_cyc[0] + i) begin
        err++;
        $display("FAIL happy_data[%0d] got %h cyc %0d want %h/%0d", i,
                 data_q[i], data_cyc[i], exp_data[i], data_cyc[0] + i);
      end
    end
    vec++;
    if (rd_cyc.size() > 0 && data_cyc.size() > 0 &&
        data_cyc[0] != rd_cyc[0] + 2) begin
      err++;
      $display("FAIL happy_latency got %0d want 2", data_cyc[0] - rd_cyc[0]);
    end
    vec++;
    if (o_done !== 1'b1 || o_count !== 8'd18 || o_busy !== 1'b0) begin
      err++;
      $display("FAIL happy_end done %b count %0d busy %b want 1/18/0",
               o_done, o_count, o_busy);
    end
  endtask

  task automatic test_backpressure();
    int hold = 0;
    int rd_at_hold = 0;
    int rd_in_hold = -1;
    clear_log();
    i_ready = 1'b0;
    start_pass();
    for (int i = 0; i < 400 && !o_done; i++) begin
      if (data_q.size() >= 6 && hold < 20) begin
        if (hold == 0) rd_at_hold = rd_addr.size();
        i_ready = 1'b0;
        hold++;
      end else begin
        if (hold == 20 && rd_in_hold < 0) rd_in_hold = rd_addr.size() - rd_at_hold;
        i_ready = 1'($urandom_range(0, 1));
      end
      tick();
    end
    i_ready = 1'b1;
    vec++;
    if (o_done !== 1'b1 || o_count !== 8'd18) begin
      err++;
      $display("FAIL bp_end done %b count %0d want 1/18", o_done, o_count);
    end
    vec++;
    if (data_q.size() != 18) begin
      err++;
      $display("FAIL bp_len got %0d want 18", data_q.size());
    end
    for (int i = 0; i < 18 && i < data_q.size(); i++) begin
      vec++;
      if (data_q[i] !== exp_data[i]) begin
        err++;
        $display("FAIL bp_data[%0d] got %h want %h", i, data_q[i], exp_data[i]);
      end
    end
    vec++;
    if (stall_viol != 0 || stab_viol != 0) begin
      err++;
      $display("FAIL bp_credit stall %0d unstable %0d want 0/0",
               stall_viol, stab_viol);
    end
    vec++;
    if (rd_in_hold < 0 || rd_in_hold > 2) begin
      err++;
      $display("FAIL bp_hold_reads got %0d want 0..2", rd_in_hold);
    end
  endtask

  task automatic test_late_cores();
    bit ok;
    int fall_cyc;
    clear_log();
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_busy  = 4'b0000;
    repeat (100) tick();
    vec++;
    if (rd_addr.size() != 0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      err++;
      $display("FAIL late_idle reads %0d busy %b done %b want 0/1/0",
               rd_addr.size(), o_busy, o_done);
    end
    i_busy = 4'b1000;
    repeat (5) tick();
    vec++;
    if (rd_addr.size() != 0) begin
      err++;
      $display("FAIL late_busy reads %0d want 0", rd_addr.size());
    end
    i_busy   = 4'b0000;
    fall_cyc = cyc + 1;
    wait_done(200, ok);
    vec++;
    if (!ok || rd_addr.size() != 18 || data_q.size() != 18) begin
      err++;
      $display("FAIL late_pass done %b reads %0d xfers %0d want 1/18/18",
               ok, rd_addr.size(), data_q.size());
    end
    vec++;
    if (rd_cyc.size() == 0 || rd_cyc[0] <= fall_cyc) begin
      err++;
      $display("FAIL late_first_rd cyc %0d want >%0d",
               rd_cyc.size() ? rd_cyc[0] : -1, fall_cyc);
    end
  endtask

  task automatic test_restart();
    bit ok;
    clear_log();
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    vec++;
    if (o_done !== 1'b0 || o_count !== 8'd0 || o_busy !== 1'b1) begin
      err++;
      $display("FAIL restart_arm done %b count %0d busy %b want 0/0/1",
               o_done, o_count, o_busy);
    end
    repeat (3) tick();
    i_start = 1'b0;
    i_busy  = 4'b0100;
    repeat (5) tick();
    i_busy  = 4'b0000;
    wait_done(200, ok);
    vec++;
    if (!ok || o_count !== 8'd18 || data_q.size() != 18) begin
      err++;
      $display("FAIL restart_pass done %b count %0d xfers %0d want 1/18/18",
               ok, o_count, data_q.size());
    end
    for (int i = 0; i < 18 && i < data_q.size(); i++) begin
      vec++;
      if (data_q[i] !== exp_data[i]) begin
        err++;
        $display("FAIL restart_data[%0d] got %h want %h", i, data_q[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_ignored_start();
    bit ok;
    clear_log();
    i_ready = 1'b1;
    start_pass();
    for (int i = 0; i < 20; i++) begin
      i_start = (i % 2 == 0);
      tick();
    end
    i_start = 1'b0;
    wait_done(200, ok);
    vec++;
    if (!ok || o_count !== 8'd18) begin
      err++;
      $display("FAIL ign_end done %b count %0d want 1/18", ok, o_count);
    end
    vec++;
    if (rd_addr.size() != 18 || data_q.size() != 18) begin
      err++;
      $display("FAIL ign_len reads %0d xfers %0d want 18/18",
               rd_addr.size(), data_q.size());
    end
    for (int i = 0; i < 18 && i < rd_addr.size() && i < data_q.size(); i++) begin
      vec++;
      if (rd_addr[i] !== 16'h0024 + 16'(i) || data_q[i] !== exp_data[i]) begin
        err++;
        $display("FAIL ign_elem[%0d] addr %h data %h want %h/%h", i,
                 rd_addr[i], data_q[i], 16'h0024 + 16'(i), exp_data[i]);
      end
    end
    tick();
    vec++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      err++;
      $display("FAIL ign_stay_done done %b busy %b want 1/0", o_done, o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_backpressure();
    test_late_cores();
    test_restart();
    test_ignored_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
